// File: rtl/track_recorder.sv
// -----------------------------------------------------------------------------
// track_recorder
//
// Pattern writer for the step sequencer. Live pad hits are synchronised,
// debounced with a lockout window, quantised to the nearest step using a
// measured step period, and written into the 16-step pattern that the track
// iterator plays back.
//
// State table:
//   state  | meaning
//   IDLE   | not recording; hits only pulse hit_accepted
//   ARMED  | waiting for the loop start (step_tick with track_iter == 0)
//   RECORD | hits are written into track_vec
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   pad_in       raw pad button, asynchronous to clk
//   step_tick    one-cycle pulse; track_iter already holds the new step
//   track_iter   current playback step
//   rec_start    one-cycle pulse, arms recording from IDLE
//   rec_stop     one-cycle pulse, aborts ARMED/RECORD
//   overdub      1 = OR hits into the pattern, 0 = overwrite reached steps
//   loop_rec     1 = keep recording across loop wraps
//   clear        one-cycle pulse, zeroes the pattern and the pending hit
//   track_vec    step pattern
//   state        00 IDLE, 01 ARMED, 10 RECORD
//   hit_accepted one-cycle pulse per accepted hit (any state)
//   rec_led      high in RECORD, toggles per step_tick in ARMED
// -----------------------------------------------------------------------------
module track_recorder #(
    parameter int unsigned       STEPS       = 16,
    parameter int unsigned       PHASE_W     = 24,
    parameter int unsigned       LOCKOUT_CYC = 2500000,
    parameter logic [STEPS-1:0]  INIT_VEC    = 16'h0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pad_in,
    input  logic                     step_tick,
    input  logic [$clog2(STEPS)-1:0] track_iter,
    input  logic                     rec_start,
    input  logic                     rec_stop,
    input  logic                     overdub,
    input  logic                     loop_rec,
    input  logic                     clear,
    output logic [STEPS-1:0]         track_vec,
    output logic [1:0]               state,
    output logic                     hit_accepted,
    output logic                     rec_led
);

    localparam int unsigned IDX_W  = $clog2(STEPS);
    localparam int unsigned LOCK_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
    localparam logic [LOCK_W-1:0]  LOCK_LOAD = LOCK_W'(LOCKOUT_CYC - 1);
    localparam logic [PHASE_W-1:0] PHASE_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ARMED  = 2'b01,
        S_RECORD = 2'b10
    } state_t;

    state_t             state_q, state_d;

    logic               sync1_q, sync2_q, sync3_q;
    logic               hit_q, hit_d;
    logic [LOCK_W-1:0]  lock_q, lock_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] period_q, period_d;
    logic [PHASE_W-1:0] phase_inc;
    logic [STEPS-1:0]   vec_q, vec_d;
    logic               pend_q, pend_d;
    logic               led_q, led_d;

    logic               rise;
    logic               accept;
    logic               early;
    logic [IDX_W-1:0]   target;
    logic               stop_act;
    logic               start_ev;
    logic               rec_tick;
    logic               exit_ev;
    logic               step_ev;
    logic               rec_hit;

    // ------------------------------------------------------------------
    // Pad path, lockout and period measurement
    // ------------------------------------------------------------------
    always_comb begin
        rise      = sync2_q & ~sync3_q;
        accept    = rise && (lock_q == '0);
        hit_d     = accept;

        lock_d = lock_q;
        if (accept) begin
            lock_d = LOCK_LOAD;
        end else if (lock_q != '0) begin
            lock_d = lock_q - 1'b1;
        end

        phase_inc = (phase_q == PHASE_MAX) ? PHASE_MAX : phase_q + 1'b1;
        phase_d   = step_tick ? '0 : phase_inc;
        // phase+1 on the tick is the number of cycles the finished step lasted
        period_d  = step_tick ? phase_inc : period_q;

        // Quantisation looks at the phase before any clear in this cycle
        early  = (period_q == '0) || (phase_q < (period_q >> 1));
        target = early ? track_iter : track_iter + 1'b1;
    end

    // ------------------------------------------------------------------
    // Recording events
    // ------------------------------------------------------------------
    always_comb begin
        stop_act = rec_stop && (state_q != S_IDLE);
        start_ev = (state_q == S_ARMED) && !stop_act && step_tick && (track_iter == '0);
        rec_tick = (state_q == S_RECORD) && !stop_act && step_tick;
        exit_ev  = rec_tick && (track_iter == '0) && !loop_rec;
        step_ev  = start_ev || (rec_tick && !exit_ev);
        rec_hit  = accept && (state_q == S_RECORD) && !stop_act;
    end

    // Pattern writes: step-start / exit first, then an early hit, clear last
    always_comb begin
        vec_d  = vec_q;
        pend_d = pend_q;

        if (exit_ev) begin
            vec_d[0] = vec_q[0] | pend_q;
            pend_d   = 1'b0;
        end
        if (step_ev) begin
            vec_d[track_iter] = overdub ? (vec_q[track_iter] | pend_q) : pend_q;
            pend_d            = 1'b0;
        end
        if (rec_hit && early) begin
            vec_d[target] = 1'b1;
        end
        // A late hit on the exit tick has no step left to land in
        if (rec_hit && !early && !exit_ev) begin
            pend_d = 1'b1;
        end
        if (stop_act) begin
            pend_d = 1'b0;
        end
        if (clear) begin
            vec_d  = '0;
            pend_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rec_start) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (stop_act) begin
                    state_d = S_IDLE;
                end else if (start_ev) begin
                    state_d = S_RECORD;
                end
            end
            S_RECORD: begin
                if (stop_act || exit_ev) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        state        = state_q;
        rec_led      = (state_q == S_RECORD) || ((state_q == S_ARMED) && led_q);
        hit_accepted = hit_q;
        track_vec    = vec_q;
    end

    // Blink phase only runs while armed; it restarts from 0 on every arm
    always_comb begin
        led_d = (state_q == S_ARMED) ? (led_q ^ step_tick) : 1'b0;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
            hit_q    <= 1'b0;
            lock_q   <= '0;
            phase_q  <= '0;
            period_q <= '0;
            vec_q    <= INIT_VEC;
            pend_q   <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            sync1_q  <= pad_in;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            hit_q    <= hit_d;
            lock_q   <= lock_d;
            phase_q  <= phase_d;
            period_q <= period_d;
            vec_q    <= vec_d;
            pend_q   <= pend_d;
            led_q    <= led_d;
        end
    end

endmodule

// File: tb/tb_track_recorder.sv
module tb_track_recorder;

    localparam int          LOCK = 500;
    localparam logic [15:0] INIT = 16'h00F0;
    localparam int          PMAX = 16777215;

    logic        clk = 1'b0;
    logic        reset, pad_in, step_tick, rec_start, rec_stop, overdub, loop_rec, clear;
    logic [3:0]  track_iter;
    logic [15:0] track_vec;
    logic [1:0]  state;
    logic        hit_accepted, rec_led;

    always #5 clk = ~clk;

    track_recorder #(
        .STEPS(16), .PHASE_W(24), .LOCKOUT_CYC(LOCK), .INIT_VEC(INIT)
    ) dut (
        .clk(clk), .reset(reset), .pad_in(pad_in), .step_tick(step_tick),
        .track_iter(track_iter), .rec_start(rec_start), .rec_stop(rec_stop),
        .overdub(overdub), .loop_rec(loop_rec), .clear(clear),
        .track_vec(track_vec), .state(state), .hit_accepted(hit_accepted),
        .rec_led(rec_led)
    );

    // bookkeeping
    int checks, passes, hit_count;
    // stimulus timebase
    int per_tb, pos, iter;
    // reference model
    int          n_cyc, last_tick, m_per, next_ok, arm_ticks;
    bit          padh[$];
    logic [15:0] m_vec;
    int          m_st;
    bit          m_pend, m_hit;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_vec = INIT; m_st = 0; m_pend = 0; m_hit = 0; m_per = 0; arm_ticks = 0;
        padh = '{0, 0, 0, 0};
        next_ok = n_cyc;
        last_tick = n_cyc - 1;
    endtask

    // Advances the model by one clock cycle using the inputs now on the pins.
    task automatic model_step();
        int  n, ph, tgt, s;
        bit  rise, acc, early, stop, start_ev, rtick, exit_ev, step_ev, rhit;
        n = n_cyc;
        padh.push_back(pad_in);
        void'(padh.pop_front());
        // edge reaches the decision point two cycles after the pad sample
        rise = padh[1] && !padh[0];
        acc  = rise && (n >= next_ok);
        if (acc) next_ok = n + LOCK;
        ph = n - last_tick - 1;
        if (ph > PMAX) ph = PMAX;
        early = (m_per == 0) || (ph < m_per / 2);
        s   = int'(track_iter);
        tgt = early ? s : (s + 1) % 16;
        stop     = rec_stop && (m_st != 0);
        start_ev = (m_st == 1) && !stop && step_tick && (s == 0);
        rtick    = (m_st == 2) && !stop && step_tick;
        exit_ev  = rtick && (s == 0) && !loop_rec;
        step_ev  = start_ev || (rtick && !exit_ev);
        rhit     = acc && (m_st == 2) && !stop;

        if (exit_ev) begin m_vec[0] = m_vec[0] | m_pend; end
        if (step_ev) begin m_vec[s] = overdub ? (m_vec[s] | m_pend) : m_pend; end
        if (rhit && early) m_vec[tgt] = 1'b1;
        if (clear) m_vec = 16'h0000;
        if (step_ev || exit_ev) m_pend = 0;
        if (rhit && !early && !exit_ev) m_pend = 1;
        if (stop || clear) m_pend = 0;

        if (m_st == 1 && step_tick) arm_ticks++;
        if (m_st == 0) begin
            if (rec_start) begin m_st = 1; arm_ticks = 0; end
        end else if (stop || exit_ev) m_st = 0;
        else if (start_ev) m_st = 2;

        if (step_tick) begin
            m_per = (ph + 1 > PMAX) ? PMAX : ph + 1;
            last_tick = n;
        end
        m_hit = acc;
        n_cyc++;
    endtask

    // One clock: model, edge, compare every output, drop single-cycle pulses.
    task automatic tick_cycle();
        bit m_led;
        model_step();
        @(negedge clk);
        m_led = (m_st == 2) || (m_st == 1 && arm_ticks[0]);
        check("track_vec", track_vec, m_vec);
        check("state", state, m_st);
        check("hit_accepted", hit_accepted, m_hit);
        check("rec_led", rec_led, m_led);
        if (hit_accepted) hit_count++;
        step_tick = 0; rec_start = 0; rec_stop = 0; clear = 0;
    endtask

    task automatic cycle_auto();
        pos = (pos >= per_tb - 1) ? 0 : pos + 1;
        if (pos == 0) begin
            step_tick = 1;
            iter = (iter + 1) % 16;
            track_iter = 4'(iter);
        end
        tick_cycle();
    endtask

    task automatic wait_at(input int step, input int p);
        bit done;
        done = 0;
        for (int i = 0; i < 40000 && !done; i++) begin
            if (iter == step && pos == p) done = 1;
            else cycle_auto();
        end
        if (!done) begin
            checks++;
            $display("FAIL wait_at: step %0d pos %0d not reached", step, p);
        end
    endtask

    task automatic pad_hit();
        pad_in = 1;
        repeat (4) cycle_auto();
        pad_in = 0;
        cycle_auto();
    endtask

    task automatic do_reset();
        pad_in = 0;
        #2 reset = 1;
        #1;
        check("rst_vec", track_vec, INIT);
        check("rst_state", state, 0);
        check("rst_led", rec_led, 0);
        check("rst_hit", hit_accepted, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    int h0;

    initial begin
        reset = 1; pad_in = 0; step_tick = 0; track_iter = 0; rec_start = 0;
        rec_stop = 0; overdub = 0; loop_rec = 0; clear = 0;
        checks = 0; passes = 0; hit_count = 0; n_cyc = 0;
        iter = 0; pos = 0; per_tb = 1000;
        repeat (2) @(negedge clk);
        check("init_vec", track_vec, 16'h00F0);
        check("init_state", state, 0);
        check("init_led", rec_led, 0);
        reset = 0;
        model_reset();

        // Period 1000, overwrite, one loop without loop_rec
        iter = 12; track_iter = 4'd12; pos = 999;
        clear = 1; cycle_auto();
        wait_at(15, 10);
        rec_start = 1; cycle_auto();
        check("armed", state, 1);
        wait_at(0, 0);
        check("record", state, 2);
        wait_at(0, 100);  pad_hit();
        wait_at(4, 100);  pad_hit();
        wait_at(7, 700);  pad_hit();
        wait_at(15, 600); pad_hit();
        wait_at(0, 0);
        check("loop_vec", track_vec, 16'h0111);
        check("loop_exit", state, 0);

        // Faster steps: build 0x8001, then overdub and overwrite a step-3 hit
        per_tb = 64;
        clear = 1; cycle_auto();
        wait_at(15, 5);
        rec_start = 1; cycle_auto();
        wait_at(0, 0);
        wait_at(0, 10);  pad_hit();
        wait_at(15, 10); pad_hit();
        wait_at(0, 0);
        check("base_vec", track_vec, 16'h8001);
        overdub = 1; rec_start = 1; cycle_auto();
        wait_at(0, 0);
        wait_at(3, 10); pad_hit();
        wait_at(0, 0);
        check("overdub_vec", track_vec, 16'h8009);
        overdub = 0; rec_start = 1; cycle_auto();
        wait_at(0, 0);
        wait_at(3, 10); pad_hit();
        wait_at(0, 0);
        check("overwrite_vec", track_vec, 16'h0008);

        // Lockout: second edge 100 cycles later ignored, third 600 later taken
        wait_at(2, 0);
        h0 = hit_count;
        pad_hit(); repeat (95) cycle_auto();
        pad_hit(); repeat (20) cycle_auto();
        check("lockout_one", hit_count - h0, 1);
        repeat (575) cycle_auto();
        pad_hit(); repeat (5) cycle_auto();
        check("lockout_two", hit_count - h0, 2);

        // Arm at step 5, blink, record from 0, late hit then abort in step 9
        clear = 1; cycle_auto();
        wait_at(5, 10);
        rec_start = 1; cycle_auto();
        check("arm5_state", state, 1);
        check("arm5_led0", rec_led, 0);
        wait_at(6, 0);
        check("arm_led1", rec_led, 1);
        wait_at(7, 0);
        check("arm_led2", rec_led, 0);
        wait_at(0, 0);
        check("arm_to_rec", state, 2);
        check("rec_led_on", rec_led, 1);
        wait_at(9, 40); pad_hit();
        rec_stop = 1; cycle_auto();
        check("stop_state", state, 0);
        wait_at(10, 5);
        check("stop_no_bit10", track_vec, 16'h0000);

        // clear against an early hit, loop_rec across the wrap, then reset mid-record
        loop_rec = 1; rec_start = 1; cycle_auto();
        wait_at(0, 0);
        wait_at(2, 10); pad_hit();
        check("pre_clear_vec", track_vec, 16'h0004);
        wait_at(12, 10);
        pad_in = 1; cycle_auto();
        cycle_auto();
        clear = 1; cycle_auto();
        check("clear_vec", track_vec, 16'h0000);
        check("clear_state", state, 2);
        check("clear_hit", hit_accepted, 1);
        pad_in = 0;
        wait_at(0, 0);
        check("loop_rec_stay", state, 2);
        wait_at(1, 5);
        do_reset();
        loop_rec = 0;

        // Randomised run against the model
        for (int i = 0; i < 30000; i++) begin
            if ($urandom_range(0, 2999) == 0) per_tb = int'($urandom_range(20, 80));
            if ($urandom_range(0, 29) == 0) pad_in = ~pad_in;
            if ($urandom_range(0, 199) == 0) rec_start = 1;
            if ($urandom_range(0, 599) == 0) rec_stop = 1;
            if ($urandom_range(0, 799) == 0) clear = 1;
            if ($urandom_range(0, 299) == 0) overdub = ~overdub;
            if ($urandom_range(0, 299) == 0) loop_rec = ~loop_rec;
            cycle_auto();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
